// File: rtl/game_fsm_if.sv
// Handshake bundle between the game sequencer and the board.
//   master (sequencer): drives chk_*, lock_valid, bar_valid/bar_row and clr_valid;
//                       receives chk_ready/chk_ok, lock_done/lines and bar_done.
//   slave  (board)    : the mirror image.
// Every request holds valid and payload until its ready/done.
interface game_fsm_if;
  logic              chk_valid;
  logic [2:0]        chk_kind;
  logic [1:0]        chk_rot;
  logic signed [4:0] chk_x;
  logic signed [5:0] chk_y;
  logic              chk_ready;
  logic              chk_ok;
  logic              lock_valid;
  logic              lock_done;
  logic [2:0]        lines;
  logic              bar_valid;
  logic [9:0]        bar_row;
  logic              bar_done;
  logic              clr_valid;

  modport master (
    output chk_valid, chk_kind, chk_rot, chk_x, chk_y, lock_valid, bar_valid, bar_row, clr_valid,
    input  chk_ready, chk_ok, lock_done, lines, bar_done
  );

  modport slave (
    input  chk_valid, chk_kind, chk_rot, chk_x, chk_y, lock_valid, bar_valid, bar_row, clr_valid,
    output chk_ready, chk_ok, lock_done, lines, bar_done
  );
endinterface

// File: rtl/game_fsm.sv
// Falling-block game sequencer. Applies one upstream command per WAIT visit, asks the board
// for collision tests, locks pieces, pushes garbage rows and keeps score.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   control           command queue head (phase encoding), state = current phase
//   rng               random word, rng[2:0] picks the spawned kind (7 maps to 0)
//   bar_mask          garbage-row hole mask, captured when BAR is entered
//   bus               game_fsm_if.master: check / lock / bar / clear handshakes
//   kind, rot, pos_x, pos_y, hold_kind, score   active piece, held piece (F = empty), score
// Build option: define WALLKICK_EN to retry a failed rotation at x-1, then x+1.
module game_fsm (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        control,
  output logic [3:0]        state,
  input  logic [31:0]       rng,
  input  logic [9:0]        bar_mask,
  game_fsm_if.master        bus,
  output logic [2:0]        kind,
  output logic [1:0]        rot,
  output logic signed [4:0] pos_x,
  output logic signed [5:0] pos_y,
  output logic [3:0]        hold_kind,
  output logic [15:0]       score
);

  typedef enum logic [3:0] {
    PhNone, PhInit, PhWait, PhLeft, PhRight, PhDown,
    PhRotate, PhRotateRev, PhDrop, PhHold, PhBar, PhEnd
  } phase_e;

  // Sub-step inside a phase; the visible state only shows the phase.
  typedef enum logic [2:0] {
    StStart, StMove, StKick, StLock, StSpawn, StFinal, StBar, StRetest
  } step_e;

  phase_e            state_q;
  step_e             step_q;
  logic [1:0]        kick_q;
  logic [2:0]        kind_q;
  logic [1:0]        rot_q;
  logic signed [4:0] pos_x_q;
  logic signed [5:0] pos_y_q;
  logic [3:0]        hold_kind_q;
  logic              hold_used_q;
  logic [15:0]       score_q;
  logic              chk_valid_q, lock_valid_q, bar_valid_q, clr_valid_q;
  logic [2:0]        chk_kind_q;
  logic [1:0]        chk_rot_q;
  logic signed [4:0] chk_x_q;
  logic signed [5:0] chk_y_q;
  logic [9:0]        bar_row_q;

  logic [1:0]        cand_rot;
  logic signed [4:0] cand_x;
  logic signed [5:0] cand_y;
  logic [2:0]        spawn_kind;
  logic              do_init;
  logic              unused_rng;

  assign spawn_kind = (rng[2:0] == 3'd7) ? 3'd0 : rng[2:0];
  assign unused_rng = ^rng[31:3];
  assign do_init    = (control == 4'(PhInit)) &&
                      (state_q == PhNone || state_q == PhEnd || state_q == PhWait);

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [15:0] line_points(input logic [2:0] n);
    case (n)
      3'd1:    return 16'd100;
      3'd2:    return 16'd300;
      3'd3:    return 16'd500;
      3'd4:    return 16'd800;
      default: return 16'd0;
    endcase
  endfunction

  // Candidate placement for the phase's move; kick_q overrides x on wall-kick retries.
  always_comb begin
    cand_rot = rot_q;
    cand_x   = pos_x_q;
    cand_y   = pos_y_q;
    case (state_q)
      PhLeft:         cand_x   = pos_x_q - 5'sd1;
      PhRight:        cand_x   = pos_x_q + 5'sd1;
      PhDown, PhDrop: cand_y   = pos_y_q + 6'sd1;
      PhRotate:       cand_rot = rot_q + 2'd1;
      PhRotateRev:    cand_rot = rot_q - 2'd1;
      default:        ;
    endcase
    if (kick_q == 2'd1) cand_x = pos_x_q - 5'sd1;
    if (kick_q == 2'd2) cand_x = pos_x_q + 5'sd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PhNone;
      step_q       <= StStart;
      kick_q       <= 2'd0;
      kind_q       <= 3'd0;
      rot_q        <= 2'd0;
      pos_x_q      <= 5'sd3;
      pos_y_q      <= 6'sd0;
      hold_kind_q  <= 4'hF;
      hold_used_q  <= 1'b0;
      score_q      <= 16'd0;
      chk_valid_q  <= 1'b0;
      lock_valid_q <= 1'b0;
      bar_valid_q  <= 1'b0;
      clr_valid_q  <= 1'b0;
      chk_kind_q   <= 3'd0;
      chk_rot_q    <= 2'd0;
      chk_x_q      <= 5'sd0;
      chk_y_q      <= 6'sd0;
      bar_row_q    <= 10'd0;
    end else begin
      clr_valid_q <= 1'b0;
      if (do_init) begin
        state_q     <= PhInit;
        step_q      <= StSpawn;
        clr_valid_q <= 1'b1;
        score_q     <= 16'd0;
        hold_kind_q <= 4'hF;
        hold_used_q <= 1'b0;
      end else if (state_q == PhNone || state_q == PhEnd) begin
        // Anything but INIT is ignored here.
      end else if (state_q == PhWait) begin
        if (control != 4'(PhNone) && control <= 4'(PhEnd)) begin
          state_q <= phase_e'(control);
          step_q  <= StStart;
          kick_q  <= 2'd0;
          if (control == 4'(PhBar)) begin
            bar_row_q   <= bar_mask;
            bar_valid_q <= 1'b1;
            step_q      <= StBar;
          end
        end
      end else begin
        unique case (step_q)
          StStart: begin
            kick_q <= 2'd0;
            case (state_q)
              PhLeft, PhRight, PhDown, PhRotate, PhRotateRev, PhDrop: begin
                chk_valid_q <= 1'b1;
                chk_kind_q  <= kind_q;
                chk_rot_q   <= cand_rot;
                chk_x_q     <= cand_x;
                chk_y_q     <= cand_y;
                step_q      <= StMove;
              end
              PhHold: begin
                if (hold_used_q) begin
                  state_q <= PhWait;
                end else begin
                  hold_used_q <= 1'b1;
                  hold_kind_q <= {1'b0, kind_q};
                  if (hold_kind_q == 4'hF) begin
                    step_q <= StSpawn;
                  end else begin
                    kind_q      <= hold_kind_q[2:0];
                    rot_q       <= 2'd0;
                    pos_x_q     <= 5'sd3;
                    pos_y_q     <= 6'sd0;
                    chk_valid_q <= 1'b1;
                    chk_kind_q  <= hold_kind_q[2:0];
                    chk_rot_q   <= 2'd0;
                    chk_x_q     <= 5'sd3;
                    chk_y_q     <= 6'sd0;
                    step_q      <= StFinal;
                  end
                end
              end
              default: state_q <= PhWait;
            endcase
          end
          StMove: begin
            if (bus.chk_ready) begin
              chk_valid_q <= 1'b0;
              if (bus.chk_ok) begin
                rot_q   <= chk_rot_q;
                pos_x_q <= chk_x_q;
                pos_y_q <= chk_y_q;
                if (state_q == PhDrop) begin
                  score_q <= sat_add(score_q, 16'd1);
                  step_q  <= StStart;
                end else begin
                  state_q <= PhWait;
                  step_q  <= StStart;
                end
              end else if (state_q == PhDown || state_q == PhDrop) begin
                lock_valid_q <= 1'b1;
                step_q       <= StLock;
              end
`ifdef WALLKICK_EN
              else if ((state_q == PhRotate || state_q == PhRotateRev) && kick_q != 2'd2) begin
                kick_q <= kick_q + 2'd1;
                step_q <= StKick;
              end
`endif
              else begin
                state_q <= PhWait;
                step_q  <= StStart;
              end
            end
          end
          StKick: begin
            // Idle cycle between attempts, then retry with the shifted x.
            chk_valid_q <= 1'b1;
            chk_x_q     <= cand_x;
            step_q      <= StMove;
          end
          StLock: begin
            if (bus.lock_done) begin
              lock_valid_q <= 1'b0;
              score_q      <= sat_add(score_q, line_points(bus.lines));
              hold_used_q  <= 1'b0;
              step_q       <= StSpawn;
            end
          end
          StSpawn: begin
            kind_q      <= spawn_kind;
            rot_q       <= 2'd0;
            pos_x_q     <= 5'sd3;
            pos_y_q     <= 6'sd0;
            chk_valid_q <= 1'b1;
            chk_kind_q  <= spawn_kind;
            chk_rot_q   <= 2'd0;
            chk_x_q     <= 5'sd3;
            chk_y_q     <= 6'sd0;
            step_q      <= StFinal;
          end
          StFinal: begin
            if (bus.chk_ready) begin
              chk_valid_q <= 1'b0;
              state_q     <= bus.chk_ok ? PhWait : PhEnd;
              step_q      <= StStart;
            end
          end
          StBar: begin
            if (bus.bar_done) begin
              bar_valid_q <= 1'b0;
              step_q      <= StRetest;
            end
          end
          StRetest: begin
            chk_valid_q <= 1'b1;
            chk_kind_q  <= kind_q;
            chk_rot_q   <= rot_q;
            chk_x_q     <= pos_x_q;
            chk_y_q     <= pos_y_q;
            step_q      <= StFinal;
          end
        endcase
      end
    end
  end

  assign state          = state_q;
  assign kind           = kind_q;
  assign rot            = rot_q;
  assign pos_x          = pos_x_q;
  assign pos_y          = pos_y_q;
  assign hold_kind      = hold_kind_q;
  assign score          = score_q;
  assign bus.chk_valid  = chk_valid_q;
  assign bus.chk_kind   = chk_kind_q;
  assign bus.chk_rot    = chk_rot_q;
  assign bus.chk_x      = chk_x_q;
  assign bus.chk_y      = chk_y_q;
  assign bus.lock_valid = lock_valid_q;
  assign bus.bar_valid  = bar_valid_q;
  assign bus.bar_row    = bar_row_q;
  assign bus.clr_valid  = clr_valid_q;

endmodule

// File: doc/game_fsm.md
GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 control  in  state_type  head of the upstream command queue; sampled only while state==WAIT, or while state is NONE/END for INIT.
REQ-004 state  out  state_type  current phase (NONE, INIT, WAIT, LEFT, RIGHT, DOWN, ROTATE, ROTATE_REV, DROP, HOLD, BAR, END); fed back upstream.
REQ-005 rng  in  32  free-running random word; rng[2:0] selects the spawn kind.
REQ-006 bar_mask  in  10  garbage-row hole mask, captured on BAR entry.
REQ-007 chk_valid/chk_kind[2:0]/chk_rot[1:0]/chk_x[4:0] signed/chk_y[5:0] signed  out  collision-test request to the board.
REQ-008 chk_ready, chk_ok  in  1,1  board accepts the test; chk_ok=1 means no collision; both are valid in the same cycle.
REQ-009 lock_valid  out  1  write the current piece into the board.
REQ-010 lock_done  in  1  lock complete; lines[2:0] is valid in the same cycle.
REQ-011 lines  in  3  rows cleared by the lock, 0..4.
REQ-012 bar_valid  out  1  push a garbage row; bar_row[9:0] carries the captured mask.
REQ-013 bar_done  in  1  push complete.
REQ-014 clr_valid  out  1  one-cycle pulse that clears the board on INIT.
REQ-015 kind[2:0], rot[1:0], pos_x[4:0], pos_y[5:0], hold_kind[3:0]  out  active and held piece (hold_kind 4'hF = empty).
REQ-016 score[15:0]  out  running score.

Function
REQ-017 Each request (chk/lock/bar) SHALL hold valid and all payload stable until its ready/done; the same request SHALL NOT be re-issued in the cycle after completion.
REQ-018 NONE or END with control==INIT -> INIT: clr_valid, score=0, hold_kind=F, hold_used=0, then spawn.
REQ-019 Spawn SHALL set kind=rng[2:0] (7 maps to 0), rot=0, x=3, y=0; chk ok -> WAIT, fail -> END.
REQ-020 WAIT with control!=NONE SHALL move state to control on the next edge; WAIT with NONE SHALL remain WAIT.
REQ-021 LEFT/RIGHT SHALL test x-1/x+1; ok commits, fail leaves the piece unchanged; both return to WAIT.
REQ-022 ROTATE/ROTATE_REV SHALL test rot+1/rot-1 mod 4; same commit rule.
REQ-023 DOWN SHALL test y+1: ok commits; fail -> lock sequence.
REQ-024 Lock sequence: lock_valid until lock_done; score += {0,100,300,500,800}[lines], saturating at 16'hFFFF; hold_used=0; spawn.
REQ-025 DROP SHALL repeat the y+1 test, committing and adding 1 to score per row, until fail, then run the lock sequence.
REQ-026 HOLD with hold_used=1 SHALL return to WAIT with no change.
REQ-027 HOLD with hold_used=0 SHALL set hold_used=1: if the slot is empty, store kind and spawn; otherwise swap kinds, reset rot/x/y to the spawn values and test; fail -> END.
REQ-028 BAR SHALL pulse bar_valid with the captured mask until bar_done, then retest the piece in place: ok -> WAIT, fail -> END.
REQ-029 END SHALL hold all outputs until INIT; a control value other than INIT SHALL be ignored in END.
REQ-030 x and y arithmetic SHALL be signed; the board rejects out-of-range positions through chk_ok=0, and the block SHALL NOT clamp them.

Reset
REQ-031 rst SHALL force state=NONE, all valids=0, score=0, kind=0, rot=0, pos_x=3, pos_y=0, hold_kind=F, hold_used=0.
REQ-032 rst mid-handshake SHALL drop every valid on the next edge and discard any pending ready/done.

Configuration
REQ-033 With WALLKICK_EN defined, a failed rotation SHALL retry at x-1, then x+1; the first ok commits both rot and x.
REQ-034 With WALLKICK_EN undefined, rotation SHALL make a single test only.

Verification
REQ-035 rst, then control=INIT with rng[2:0]=5 and chk_ok=1 -> clr_valid pulse, kind=5, x=3, y=0, state=WAIT.
REQ-036 WAIT, control=LEFT, chk_ok=0 -> pos_x stays 3, returns to WAIT, exactly one chk transaction.
REQ-037 DROP with chk_ok=1 four times then 0, lock_done with lines=2 -> pos_y=4 before the lock, score += 4+300.
REQ-038 HOLD twice before any lock -> second HOLD changes nothing; hold_kind equals the first kind.
REQ-039 WALLKICK_EN, ROTATE with ok sequence 0,0,1 -> rot+1, x=original+1; undefined -> no change.
REQ-040 chk_ready held low 20 cycles during LEFT -> chk_* stable throughout; rst asserted at cycle 10 -> chk_valid=0 on the next edge, state=NONE.
